// File: rtl/battleship_game_ctrl.sv
// Battleship turn controller: ship-count selection, placement, alternating
// player/PC turns with turn timer, PC think delay/retries and win detection.
module battleship_game_ctrl #(
   parameter int SHIP_W       = 3,
   parameter int MAX_SHIPS    = 5,
   parameter int TIMER_W      = 30,
   parameter int TURN_CYCLES  = 750000000,
   parameter int PC_DELAY     = 4,
   parameter int MAX_RETRY    = 3,
   parameter int BONUS_ON_HIT = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn,
   input  logic [SHIP_W-1:0]  num_ships,
   input  logic               place_done,
   input  logic               shot_valid,
   input  logic               shot_hit,
   input  logic               shot_sunk,
   output logic [3:0]         state_o,
   output logic               sel_ships,
   output logic               place_ships,
   output logic               turn_player,
   output logic               turn_pc,
   output logic               check_en,
   output logic [TIMER_W-1:0] timer_left,
   output logic               timeout,
   output logic [SHIP_W-1:0]  ships_total,
   output logic [SHIP_W-1:0]  pc_sunk,
   output logic [SHIP_W-1:0]  player_sunk,
   output logic               game_over,
   output logic               winner
);

   localparam int DELAY_W = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;
   localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TURN_CYCLES - 1);
   localparam logic [SHIP_W-1:0]  SHIPS_MAX    = SHIP_W'(MAX_SHIPS);
   localparam logic [DELAY_W-1:0] DELAY_LAST   = DELAY_W'(PC_DELAY - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);
   localparam logic               BONUS        = (BONUS_ON_HIT != 0);

   typedef enum logic [3:0] {
      S_SELECT    = 4'd0,
      S_PLACE     = 4'd1,
      S_P_TURN    = 4'd2,
      S_P_CHECK   = 4'd3,
      S_P_EVAL    = 4'd4,
      S_PC_WAIT   = 4'd5,
      S_PC_CHECK  = 4'd6,
      S_PC_EVAL   = 4'd7,
      S_GAME_OVER = 4'd8
   } state_e;

   state_e              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                timeout_q, timeout_d;
   logic [SHIP_W-1:0]   ships_total_q, ships_total_d;
   logic [SHIP_W-1:0]   pc_sunk_q, pc_sunk_d;
   logic [SHIP_W-1:0]   player_sunk_q, player_sunk_d;
   logic                winner_q, winner_d;
   logic                hit_q, hit_d;
   logic                sunk_q, sunk_d;
   logic [DELAY_W-1:0]  delay_q, delay_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [SHIP_W-1:0]   pc_sunk_inc, player_sunk_inc;

   // Sunk counters saturate at the latched ship count.
   assign pc_sunk_inc     = (sunk_q && (pc_sunk_q < ships_total_q))     ? pc_sunk_q + 1'b1     : pc_sunk_q;
   assign player_sunk_inc = (sunk_q && (player_sunk_q < ships_total_q)) ? player_sunk_q + 1'b1 : player_sunk_q;

   always_comb begin
      // NOTE: every _d gets a default up front so no path through the case can infer a latch.
      state_d       = state_q;
      timer_d       = timer_q;
      timeout_d     = 1'b0;
      ships_total_d = ships_total_q;
      pc_sunk_d     = pc_sunk_q;
      player_sunk_d = player_sunk_q;
      winner_d      = winner_q;
      hit_d         = hit_q;
      sunk_d        = sunk_q;
      retry_d       = retry_q;

      case (state_q)
         S_SELECT: begin
            if (btn) begin
               if (num_ships == '0)           ships_total_d = SHIP_W'(1);
               else if (num_ships > SHIPS_MAX) ships_total_d = SHIPS_MAX;
               else                            ships_total_d = num_ships;
               state_d = S_PLACE;
            end
         end
         S_PLACE: begin
            if (place_done) begin
               timer_d = TIMER_RELOAD;
               state_d = S_P_TURN;
            end
         end
         S_P_TURN: begin
            retry_d = '0;
            if (timer_q != '0) timer_d = timer_q - 1'b1;
            if (btn) begin
               state_d = S_P_CHECK;
            end else if (timer_q == '0) begin
               timeout_d = 1'b1;
               state_d   = S_PC_WAIT;
            end
         end
         S_P_CHECK: begin
            if (shot_valid) begin
               hit_d   = shot_hit;
               sunk_d  = shot_sunk;
               state_d = S_P_EVAL;
            end else begin
               state_d = S_P_TURN;
            end
         end
         S_P_EVAL: begin
            retry_d   = '0;
            pc_sunk_d = pc_sunk_inc;
            if (pc_sunk_inc == ships_total_q) begin
               winner_d = 1'b0;
               state_d  = S_GAME_OVER;
            end else if (hit_q && BONUS) begin
               timer_d = TIMER_RELOAD;
               state_d = S_P_TURN;
            end else begin
               state_d = S_PC_WAIT;
            end
         end
         S_PC_WAIT: begin
            if (delay_q == DELAY_LAST) state_d = S_PC_CHECK;
         end
         S_PC_CHECK: begin
            if (shot_valid) begin
               hit_d   = shot_hit;
               sunk_d  = shot_sunk;
               state_d = S_PC_EVAL;
            end else if (retry_q == RETRY_LAST) begin
               retry_d = '0;
               timer_d = TIMER_RELOAD;
               state_d = S_P_TURN;
            end else begin
               retry_d = retry_q + 1'b1;
               state_d = S_PC_WAIT;
            end
         end
         S_PC_EVAL: begin
            retry_d       = '0;
            player_sunk_d = player_sunk_inc;
            if (player_sunk_inc == ships_total_q) begin
               winner_d = 1'b1;
               state_d  = S_GAME_OVER;
            end else if (hit_q && BONUS) begin
               state_d = S_PC_WAIT;
            end else begin
               timer_d = TIMER_RELOAD;
               state_d = S_P_TURN;
            end
         end
         S_GAME_OVER: begin
            if (btn) begin
               pc_sunk_d     = '0;
               player_sunk_d = '0;
               winner_d      = 1'b0;
               ships_total_d = '0;
               state_d       = S_SELECT;
            end
         end
         default: state_d = S_SELECT;
      endcase

      // Think delay restarts on every fresh entry into PC_WAIT.
      delay_d = ((state_q == S_PC_WAIT) && (state_d == S_PC_WAIT)) ? delay_q + 1'b1 : '0;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_SELECT;
         timer_q       <= TIMER_RELOAD;
         timeout_q     <= 1'b0;
         ships_total_q <= '0;
         pc_sunk_q     <= '0;
         player_sunk_q <= '0;
         winner_q      <= 1'b0;
         hit_q         <= 1'b0;
         sunk_q        <= 1'b0;
         delay_q       <= '0;
         retry_q       <= '0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         timeout_q     <= timeout_d;
         ships_total_q <= ships_total_d;
         pc_sunk_q     <= pc_sunk_d;
         player_sunk_q <= player_sunk_d;
         winner_q      <= winner_d;
         hit_q         <= hit_d;
         sunk_q        <= sunk_d;
         delay_q       <= delay_d;
         retry_q       <= retry_d;
      end
   end

   assign state_o     = state_q;
   assign sel_ships   = (state_q == S_SELECT);
   assign place_ships = (state_q == S_PLACE);
   assign turn_player = (state_q == S_P_TURN);
   assign turn_pc     = (state_q == S_PC_WAIT);
   assign check_en    = (state_q == S_P_CHECK) || (state_q == S_PC_CHECK);
   assign game_over   = (state_q == S_GAME_OVER);
   assign timer_left  = timer_q;
   assign timeout     = timeout_q;
   assign ships_total = ships_total_q;
   assign pc_sunk     = pc_sunk_q;
   assign player_sunk = player_sunk_q;
   assign winner      = winner_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Scoreboard bench for battleship_game_ctrl: expectations are queued with each
// stimulus step and compared once the following clock edge has settled.
module tb_battleship_game_ctrl;

   localparam int SHIP_W  = 3;
   localparam int TIMER_W = 30;
   localparam int TURN    = 20;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               btn;
   logic [SHIP_W-1:0]  num_ships;
   logic               place_done, shot_valid, shot_hit, shot_sunk;
   logic [3:0]         state_o;
   logic               sel_ships, place_ships, turn_player, turn_pc, check_en;
   logic [TIMER_W-1:0] timer_left;
   logic               timeout;
   logic [SHIP_W-1:0]  ships_total, pc_sunk, player_sunk;
   logic               game_over, winner;

   battleship_game_ctrl #(.SHIP_W(SHIP_W), .TIMER_W(TIMER_W), .TURN_CYCLES(TURN)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .num_ships(num_ships), .place_done(place_done),
      .shot_valid(shot_valid), .shot_hit(shot_hit), .shot_sunk(shot_sunk),
      .state_o(state_o), .sel_ships(sel_ships), .place_ships(place_ships),
      .turn_player(turn_player), .turn_pc(turn_pc), .check_en(check_en),
      .timer_left(timer_left), .timeout(timeout), .ships_total(ships_total),
      .pc_sunk(pc_sunk), .player_sunk(player_sunk), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   typedef enum int {SIG_STATE, SIG_DEC, SIG_TIMER, SIG_TIMEOUT, SIG_TOTAL,
                     SIG_PCS, SIG_PLS, SIG_WIN} sig_e;
   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Expected decode bits {sel, place, turn_player, turn_pc, check_en, game_over}.
   function automatic logic [31:0] dec_of(input int code);
      case (code)
         0:       return 32'b100000;
         1:       return 32'b010000;
         2:       return 32'b001000;
         3, 6:    return 32'b000010;
         5:       return 32'b000100;
         8:       return 32'b000001;
         default: return 32'b000000;
      endcase
   endfunction

   function automatic logic [31:0] observe(input sig_e s);
      case (s)
         SIG_STATE:   return 32'(state_o);
         SIG_DEC:     return 32'({sel_ships, place_ships, turn_player, turn_pc, check_en, game_over});
         SIG_TIMER:   return 32'(timer_left);
         SIG_TIMEOUT: return 32'(timeout);
         SIG_TOTAL:   return 32'(ships_total);
         SIG_PCS:     return 32'(pc_sunk);
         SIG_PLS:     return 32'(player_sunk);
         default:     return 32'(winner);
      endcase
   endfunction

   task automatic push(input string tag, input sig_e s, input int v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.val = 32'(v);
      sb_q.push_back(e);
   endtask

   task automatic exp_st(input string tag, input int code);
      push(tag, SIG_STATE, code);
      push({tag, "_dec"}, SIG_DEC, int'(dec_of(code)));
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.tag, observe(e.sig), e.val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drain();
   endtask

   // Three more PC_WAIT cycles after the entry cycle, then PC_CHECK.
   task automatic pc_think();
      for (int i = 0; i < 3; i++) begin
         exp_st("pc_wait", 5);
         step();
      end
      exp_st("pc_check", 6);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; btn = 1'b0; num_ships = '0; place_done = 1'b0;
      shot_valid = 1'b0; shot_hit = 1'b0; shot_sunk = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_st("rst", 0);
      push("rst_timer", SIG_TIMER, TURN - 1);
      push("rst_timeout", SIG_TIMEOUT, 0);
      push("rst_total", SIG_TOTAL, 0);
      push("rst_pcs", SIG_PCS, 0);
      push("rst_pls", SIG_PLS, 0);
      push("rst_win", SIG_WIN, 0);
      drain();
      rst_n = 1'b1;

      // Ship-count clamping, with asynchronous resets in between
      num_ships = 3'd0; btn = 1'b1;
      exp_st("sel0", 1); push("sel0_total", SIG_TOTAL, 1);
      step();
      btn = 1'b0;
      rst_n = 1'b0;
      exp_st("arst_place", 0); push("arst_total", SIG_TOTAL, 0);
      #1; drain();
      rst_n = 1'b1;
      num_ships = 3'd7; btn = 1'b1;
      exp_st("sel7", 1); push("sel7_total", SIG_TOTAL, 5);
      step();
      btn = 1'b0;
      rst_n = 1'b0; #1; rst_n = 1'b1;
      num_ships = 3'd2; btn = 1'b1;
      exp_st("sel2", 1); push("sel2_total", SIG_TOTAL, 2);
      step();
      btn = 1'b0;

      for (int i = 0; i < 100; i++) begin
         exp_st("place_hold", 1);
         step();
      end
      place_done = 1'b1;
      exp_st("place_done", 2); push("turn_timer", SIG_TIMER, TURN - 1);
      step();
      place_done = 1'b0;

      // Player timeout
      for (int k = 1; k < TURN; k++) begin
         exp_st("p_turn", 2);
         push("p_timer", SIG_TIMER, TURN - 1 - k);
         push("p_no_timeout", SIG_TIMEOUT, 0);
         step();
      end
      exp_st("timeout_st", 5); push("timeout_pulse", SIG_TIMEOUT, 1);
      step();
      push("timeout_end", SIG_TIMEOUT, 0);
      pc_think();

      // PC forfeits after three invalid shots
      for (int r = 0; r < 3; r++) begin
         if (r < 2) begin
            exp_st("pc_retry", 5);
            step();
            pc_think();
         end else begin
            exp_st("pc_forfeit", 2); push("forfeit_timer", SIG_TIMER, TURN - 1);
            step();
         end
      end

      // Player invalid shot at timer 12, then a valid miss
      for (int i = 0; i < 7; i++) begin
         exp_st("p_wait", 2); push("p_wait_timer", SIG_TIMER, TURN - 2 - i);
         step();
      end
      btn = 1'b1;
      exp_st("p_btn", 3); push("p_btn_timer", SIG_TIMER, 11);
      step();
      btn = 1'b0;
      exp_st("p_invalid", 2); push("p_inv_timer", SIG_TIMER, 11);
      step();
      exp_st("p_cont", 2); push("p_cont_timer", SIG_TIMER, 10);
      step();
      btn = 1'b1;
      exp_st("p_btn2", 3);
      step();
      btn = 1'b0; shot_valid = 1'b1;
      exp_st("p_eval", 4);
      step();
      shot_valid = 1'b0;
      exp_st("p_miss", 5); push("p_miss_pcs", SIG_PCS, 0);
      step();
      pc_think();

      // Two invalid PC shots do not forfeit on a fresh turn
      for (int r = 0; r < 2; r++) begin
         exp_st("pc_inv", 5);
         step();
         pc_think();
      end
      shot_valid = 1'b1; shot_hit = 1'b1;
      exp_st("pc_hit", 7);
      step();
      shot_valid = 1'b0; shot_hit = 1'b0;
      exp_st("pc_bonus", 5); push("pc_bonus_pls", SIG_PLS, 0);
      step();
      pc_think();
      shot_valid = 1'b1; shot_hit = 1'b1; shot_sunk = 1'b1;
      exp_st("pc_sink_eval", 7);
      step();
      shot_valid = 1'b0; shot_hit = 1'b0; shot_sunk = 1'b0;
      exp_st("pc_sink", 5); push("pc_sink_pls", SIG_PLS, 1);
      step();
      pc_think();
      shot_valid = 1'b1;
      exp_st("pc_miss_eval", 7);
      step();
      shot_valid = 1'b0;
      exp_st("pc_miss", 2); push("pc_miss_timer", SIG_TIMER, TURN - 1);
      push("pc_miss_pls", SIG_PLS, 1);
      step();

      // Player sinks both ships on bonus turns
      for (int s = 1; s <= 2; s++) begin
         btn = 1'b1;
         exp_st("p_shoot", 3);
         step();
         btn = 1'b0; shot_valid = 1'b1; shot_hit = 1'b1; shot_sunk = 1'b1;
         exp_st("p_sink_eval", 4);
         step();
         shot_valid = 1'b0; shot_hit = 1'b0; shot_sunk = 1'b0;
         if (s == 1) begin
            exp_st("p_bonus", 2); push("p_bonus_pcs", SIG_PCS, 1);
            push("p_bonus_timer", SIG_TIMER, TURN - 1);
         end else begin
            exp_st("p_win", 8); push("p_win_pcs", SIG_PCS, 2);
            push("p_win_winner", SIG_WIN, 0);
         end
         step();
      end
      for (int i = 0; i < 5; i++) begin
         shot_valid = 1'($urandom_range(0, 1));
         shot_hit   = 1'($urandom_range(0, 1));
         shot_sunk  = 1'($urandom_range(0, 1));
         exp_st("over_hold", 8);
         push("hold_pcs", SIG_PCS, 2);
         push("hold_pls", SIG_PLS, 1);
         step();
      end
      shot_valid = 1'b0; shot_hit = 1'b0; shot_sunk = 1'b0;
      btn = 1'b1;
      exp_st("restart", 0);
      push("restart_pcs", SIG_PCS, 0); push("restart_pls", SIG_PLS, 0);
      push("restart_total", SIG_TOTAL, 0); push("restart_win", SIG_WIN, 0);
      step();
      btn = 1'b0;

      // One-ship game won by the PC
      num_ships = 3'd1; btn = 1'b1;
      exp_st("g2_sel", 1);
      step();
      btn = 1'b0; place_done = 1'b1;
      exp_st("g2_place", 2);
      step();
      place_done = 1'b0; btn = 1'b1;
      exp_st("g2_shoot", 3);
      step();
      btn = 1'b0; shot_valid = 1'b1;
      exp_st("g2_eval", 4);
      step();
      shot_valid = 1'b0;
      exp_st("g2_pcwait", 5);
      step();
      pc_think();
      shot_valid = 1'b1; shot_hit = 1'b1; shot_sunk = 1'b1;
      exp_st("g2_pc_eval", 7);
      step();
      shot_valid = 1'b0; shot_hit = 1'b0; shot_sunk = 1'b0;
      exp_st("pc_win", 8); push("pc_win_winner", SIG_WIN, 1);
      push("pc_win_pls", SIG_PLS, 1);
      step();
      btn = 1'b1;
      exp_st("g2_restart", 0);
      step();
      btn = 1'b0;

      // Reset in the middle of PC_WAIT
      num_ships = 3'd3; btn = 1'b1;
      exp_st("g3_sel", 1);
      step();
      btn = 1'b0; place_done = 1'b1;
      exp_st("g3_place", 2);
      step();
      place_done = 1'b0; btn = 1'b1;
      exp_st("g3_shoot", 3);
      step();
      btn = 1'b0; shot_valid = 1'b1;
      exp_st("g3_eval", 4);
      step();
      shot_valid = 1'b0;
      exp_st("g3_pcwait", 5);
      step();
      exp_st("g3_pcwait2", 5);
      step();
      rst_n = 1'b0;
      exp_st("rst_mid", 0);
      push("rst_mid_timer", SIG_TIMER, TURN - 1);
      push("rst_mid_total", SIG_TOTAL, 0);
      #1; drain();
      exp_st("rst_hold", 0);
      step();
      rst_n = 1'b1;
      exp_st("rst_release", 0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
